ysyx_040750_ex_muldiv: RTL
==========================

// Module: ysyx_040750_ex_muldiv
// PURPOSE
//  Iterative RV64M multiply/divide unit in the EX stage, downstream of the ID/EX register.
//  Starts on the ID/EX one-cycle multicycle pulse and computes MUL/MULH*/DIV*/REM* (incl. W forms).
//  Drives the ALU output-valid the ID/EX register uses for handshake and allowin.
//  Single-cycle ALU ops see valid=1 immediately.
// PARAMETERS
//  XLEN        64  datapath width
//  MUL_UNROLL  1   multiplier bits retired per cycle; legal 1,2,4; must divide 32
// PORTS
//  I_sys_clk            in   1     clock; single clock domain
//  I_rst                in   1     synchronous reset, active-high
//  I_start              in   1     one-cycle pulse = ID/EX O_alu_multicycle; operands valid this cycle
//  I_op                 in   4     one-hot: [0] MUL, [1] MULH, [2] DIV, [3] REM (= alu_op_sel[13:10])
//  I_sext               in   2     [1] rs1 signed, [0] rs2 signed (MULHSU = 2'b10)
//  I_word               in   1     W-form: 32-bit operation, result sign-extended to 64
//  I_src1, I_src2       in   64    rs1 and rs2 operands
//  I_allowout           in   1     downstream (EX/MEM) accepts the result this cycle
//  O_alu_output_valid   out  1     result or pass-through valid
//  O_result             out  64    M-extension result; stable while in DONE
//  O_busy               out  1     state != IDLE
// BEHAVIOUR
//  Reset: state=IDLE, O_result=0, O_busy=0, internal counters/accumulators=0.
//  O_alu_output_valid = (IDLE && !I_start) || DONE. Combinational, so ID/EX holds during a multicycle op.
//  FSM: IDLE -> MUL | DIV | DONE; MUL -> DONE; DIV -> DONE; DONE -> IDLE.
//   IDLE: on I_start, capture operands, op, sext and word flags.
//     W forms use low 32 bits, sign- or zero-extended per I_sext.
//     Iteration count N: 64 (DIV), 64/MUL_UNROLL (MUL); 32 and 32/MUL_UNROLL for W forms.
//   MUL: unsigned shift-add on |a| and |b|; one step per cycle; counter decrements.
//     On the last step, negate the 128-bit product when signs differ; then go to DONE.
//     Select: MUL -> low 64; MULH -> high 64; W -> low 32, sign-extended.
//   DIV: restoring radix-2 on magnitudes; one quotient bit per cycle.
//     Quotient sign = sign(a) XOR sign(b); remainder sign = sign(a).
//   DONE: hold O_result; on I_allowout go to IDLE. The next I_start may arrive in the following cycle.
//  Latency: I_start in cycle T -> valid in cycle T+N+1.
//  Special cases are resolved in IDLE, go directly to DONE, and give valid at T+1:
//   divide by zero: quotient = all ones; remainder = dividend (W forms: 32-bit values, sign-extended).
//   signed overflow (MIN / -1): quotient = MIN; remainder = 0. MIN is 64-bit, or 32-bit for W.
//  I_start while not IDLE: ignored (protocol violation; the bench asserts it never occurs).
//  Reset mid-operation: back to IDLE next cycle; result discarded; valid=1.
//  I_op not one-hot at I_start: the unit behaves as MUL.
// CONFIGURATION
//  Macro YSYX_040750_MUL_EARLY_EXIT_EN:
//   defined: MUL leaves to DONE once the remaining shifted multiplier is zero.
//     Minimum 1 step, then sign-fix; latency is data-dependent (T+k+1).
//   undefined: fixed latency T+N+1 for every MUL. DIV is always fixed latency.
// STRUCTURE
//  Shared defines file ysyx_040750_muldiv_defs.vh holds:
//   op one-hot bit indices, FSM state encodings (IDLE, MUL, DIV, DONE), MIN constants.
//  Sub-module ysyx_040750_div_core: one restoring step.
//   Inputs: remainder, quotient, divisor. Outputs: next remainder and next quotient bit.
//   Top level owns the FSM, counter, sign handling and multiplier.
// TESTING
//  1 MUL: 7 * -3 (sext=11) -> valid after 65 cycles (MUL_UNROLL=1, no early exit);
//    O_result = 0xFFFF_FFFF_FFFF_FFEB.
//  2 MULHU: 0xFFFF_FFFF_FFFF_FFFF squared (sext=00) -> O_result = 0xFFFF_FFFF_FFFF_FFFE.
//  3 DIVW: -7 / 2 (sext=11, word) -> quotient 0xFFFF_FFFF_FFFF_FFFD.
//    REMW, same operands -> 0xFFFF_FFFF_FFFF_FFFF. Both after 33 cycles.
//  4 DIV and REM by zero: src1 = 42 -> DIV 0xFFFF_FFFF_FFFF_FFFF, REM 42, valid at T+1.
//    DIV 0x8000_0000_0000_0000 / -1 -> 0x8000_0000_0000_0000.
//  5 Backpressure: hold I_allowout=0 for 10 cycles in DONE -> valid and O_result stable.
//    Raise I_allowout -> IDLE next cycle.
//  6 Reset at step 20 of a DIV -> IDLE next cycle, valid=1, O_result=0.
//    Next MUL 3*5 -> 15.

Source files
------------

// File: rtl/ysyx_040750_ex_muldiv_pkg.sv
// Shared definitions for the RV64M iterative multiply/divide unit:
// op one-hot bit positions, FSM state encodings, overflow MIN constants
// and the one-hot op decoder.
package ysyx_040750_ex_muldiv_pkg;

  // Bit positions inside the one-hot I_op vector
  localparam int unsigned OP_MUL  = 0;
  localparam int unsigned OP_MULH = 1;
  localparam int unsigned OP_DIV  = 2;
  localparam int unsigned OP_REM  = 3;

  // FSM state encodings (kept as plain constants for legacy tooling)
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  // Most negative value: 64-bit, and the 32-bit one as it appears sign-extended
  localparam logic [63:0] MIN64    = 64'h8000_0000_0000_0000;
  localparam logic [63:0] MIN32_SX = 64'hFFFF_FFFF_8000_0000;

  typedef enum logic [1:0] {
    K_MUL,
    K_MULH,
    K_DIV,
    K_REM
  } kind_e;

  // Anything that is not exactly one of the known one-hot codes runs as MUL
  function automatic kind_e decode_op(input logic [3:0] op);
    kind_e k;
    k = K_MUL;
    if (op == (4'b0001 << OP_MULH)) k = K_MULH;
    else if (op == (4'b0001 << OP_DIV)) k = K_DIV;
    else if (op == (4'b0001 << OP_REM)) k = K_REM;
    return k;
  endfunction

  function automatic logic [63:0] sext32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

endpackage

// File: rtl/ysyx_040750_ex_muldiv_div_core.sv
// One restoring radix-2 division step: shift the next dividend bit into the
// partial remainder, subtract the divisor if it fits, and shift the new
// quotient bit into the quotient/dividend register.
module ysyx_040750_div_core #(
  parameter int unsigned XLEN = 64
) (
  input  logic [XLEN-1:0] i_rem,
  input  logic [XLEN-1:0] i_quo,
  input  logic [XLEN-1:0] i_dvsr,
  output logic [XLEN-1:0] o_rem,
  output logic [XLEN-1:0] o_quo
);

  logic [XLEN:0] w_shift;
  logic [XLEN:0] w_diff;
  logic          w_qbit;

  // Trial subtraction; a clear borrow bit means the divisor fits
  always_comb begin
    w_shift = {i_rem, i_quo[XLEN-1]};
    w_diff  = w_shift - {1'b0, i_dvsr};
    w_qbit  = ~w_diff[XLEN];
    o_rem   = w_qbit ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0];
    o_quo   = {i_quo[XLEN-2:0], w_qbit};
  end

endmodule

// File: rtl/ysyx_040750_ex_muldiv.sv
// Iterative RV64M multiply/divide unit for the EX stage.
// Multiply: unsigned shift-add on operand magnitudes, MUL_UNROLL bits per cycle.
// Divide: restoring radix-2 on magnitudes, one quotient bit per cycle.
// Divide-by-zero and signed overflow resolve in IDLE and finish next cycle.
// Optional macro YSYX_040750_MUL_EARLY_EXIT_EN: multiply finishes as soon as
// the remaining multiplier bits are all zero (data-dependent latency).
// The datapath is RV64; XLEN is expected to stay 64.
module ysyx_040750_ex_muldiv
  import ysyx_040750_ex_muldiv_pkg::*;
#(
  parameter int unsigned XLEN       = 64,
  parameter int unsigned MUL_UNROLL = 1
) (
  input  logic            I_sys_clk,
  input  logic            I_rst,
  input  logic            I_start,
  input  logic [3:0]      I_op,
  input  logic [1:0]      I_sext,
  input  logic            I_word,
  input  logic [XLEN-1:0] I_src1,
  input  logic [XLEN-1:0] I_src2,
  input  logic            I_allowout,
  output logic            O_alu_output_valid,
  output logic [XLEN-1:0] O_result,
  output logic            O_busy
);

  localparam int unsigned   CW     = $clog2(XLEN) + 1;
  localparam logic [CW-1:0] N_DIV  = CW'(XLEN);
  localparam logic [CW-1:0] N_DIVW = CW'(XLEN / 2);
  localparam logic [CW-1:0] N_MUL  = CW'(XLEN / MUL_UNROLL);
  localparam logic [CW-1:0] N_MULW = CW'(XLEN / 2 / MUL_UNROLL);

  logic [1:0]        r_state;
  logic [CW-1:0]     r_cnt;
  kind_e             r_kind;
  logic              r_word;
  logic              r_neg;
  logic              r_rneg;
  logic [2*XLEN-1:0] r_acc;
  logic [2*XLEN-1:0] r_mcand;
  logic [XLEN-1:0]   r_mplier;
  logic [XLEN-1:0]   r_rem;
  logic [XLEN-1:0]   r_quo;
  logic [XLEN-1:0]   r_dvsr;
  logic [XLEN-1:0]   r_result;

  kind_e             w_kind;
  logic              w_is_div;
  logic [XLEN-1:0]   w_a_ext;
  logic [XLEN-1:0]   w_b_ext;
  logic              w_a_neg;
  logic              w_b_neg;
  logic [XLEN-1:0]   w_a_mag;
  logic [XLEN-1:0]   w_b_mag;
  logic              w_div0;
  logic              w_ovf;
  logic              w_special;
  logic [XLEN-1:0]   w_spec_res;

  logic [2*XLEN-1:0] w_acc_step;
  logic [2*XLEN-1:0] w_mcand_nxt;
  logic [XLEN-1:0]   w_mplier_nxt;
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_mul_res;
  logic              w_mul_last;

  logic [XLEN-1:0]   w_rem_nxt;
  logic [XLEN-1:0]   w_quo_nxt;
  logic [XLEN-1:0]   w_q_fix;
  logic [XLEN-1:0]   w_r_fix;
  logic [XLEN-1:0]   w_div_res;

  ysyx_040750_div_core #(.XLEN(XLEN)) u_div_core (
    .i_rem  (r_rem),
    .i_quo  (r_quo),
    .i_dvsr (r_dvsr),
    .o_rem  (w_rem_nxt),
    .o_quo  (w_quo_nxt)
  );

  // Operand extension, magnitudes and special-case detection for the start cycle
  always_comb begin
    w_kind   = decode_op(I_op);
    w_is_div = (w_kind == K_DIV) || (w_kind == K_REM);
    w_a_ext  = I_src1;
    w_b_ext  = I_src2;
    if (I_word) begin
      w_a_ext = I_sext[1] ? sext32(I_src1[31:0]) : {32'b0, I_src1[31:0]};
      w_b_ext = I_sext[0] ? sext32(I_src2[31:0]) : {32'b0, I_src2[31:0]};
    end
    w_a_neg   = I_sext[1] & w_a_ext[XLEN-1];
    w_b_neg   = I_sext[0] & w_b_ext[XLEN-1];
    w_a_mag   = w_a_neg ? -w_a_ext : w_a_ext;
    w_b_mag   = w_b_neg ? -w_b_ext : w_b_ext;
    w_div0    = (w_b_ext == '0);
    w_ovf     = (I_sext == 2'b11) && (w_a_ext == (I_word ? MIN32_SX : MIN64))
                && (w_b_ext == '1);
    w_special = w_is_div && (w_div0 || w_ovf);
    if (w_kind == K_DIV)
      w_spec_res = w_div0 ? '1 : (I_word ? MIN32_SX : MIN64);
    else
      w_spec_res = w_div0 ? (I_word ? sext32(I_src1[31:0]) : I_src1) : '0;
  end

  // One shift-add multiply step plus the sign-fixed, selected result
  always_comb begin
    w_acc_step = r_acc;
    for (int unsigned u = 0; u < MUL_UNROLL; u++) begin
      if (r_mplier[u]) w_acc_step = w_acc_step + (r_mcand << u);
    end
    w_mcand_nxt  = r_mcand << MUL_UNROLL;
    w_mplier_nxt = r_mplier >> MUL_UNROLL;
    w_prod       = r_neg ? -w_acc_step : w_acc_step;
    if (r_word)
      w_mul_res = sext32(w_prod[31:0]);
    else if (r_kind == K_MULH)
      w_mul_res = w_prod[2*XLEN-1:XLEN];
    else
      w_mul_res = w_prod[XLEN-1:0];
`ifdef YSYX_040750_MUL_EARLY_EXIT_EN
    w_mul_last = (r_cnt == CW'(1)) || (w_mplier_nxt == '0);
`else
    w_mul_last = (r_cnt == CW'(1));
`endif
  end

  // Sign fix and selection of the final division result from the last step
  always_comb begin
    w_q_fix = r_neg ? -w_quo_nxt : w_quo_nxt;
    w_r_fix = r_rneg ? -w_rem_nxt : w_rem_nxt;
    if (r_kind == K_REM)
      w_div_res = r_word ? sext32(w_r_fix[31:0]) : w_r_fix;
    else
      w_div_res = r_word ? sext32(w_q_fix[31:0]) : w_q_fix;
  end

  // FSM, iteration counter and datapath registers
  always_ff @(posedge I_sys_clk) begin
    if (I_rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_kind   <= K_MUL;
      r_word   <= 1'b0;
      r_neg    <= 1'b0;
      r_rneg   <= 1'b0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_dvsr   <= '0;
      r_result <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (I_start) begin
            r_kind <= w_kind;
            r_word <= I_word;
            r_neg  <= w_a_neg ^ w_b_neg;
            r_rneg <= w_a_neg;
            if (w_special) begin
              r_result <= w_spec_res;
              r_state  <= S_DONE;
            end else if (w_is_div) begin
              // W forms park the 32-bit dividend in the upper half so its MSB shifts out first
              r_rem   <= '0;
              r_quo   <= I_word ? {w_a_mag[31:0], 32'b0} : w_a_mag;
              r_dvsr  <= w_b_mag;
              r_cnt   <= I_word ? N_DIVW : N_DIV;
              r_state <= S_DIV;
            end else begin
              r_acc    <= '0;
              r_mcand  <= {{XLEN{1'b0}}, w_a_mag};
              r_mplier <= w_b_mag;
              r_cnt    <= I_word ? N_MULW : N_MUL;
              r_state  <= S_MUL;
            end
          end
        end
        S_MUL: begin
          r_acc    <= w_acc_step;
          r_mcand  <= w_mcand_nxt;
          r_mplier <= w_mplier_nxt;
          r_cnt    <= r_cnt - CW'(1);
          if (w_mul_last) begin
            r_result <= w_mul_res;
            r_state  <= S_DONE;
          end
        end
        S_DIV: begin
          r_rem <= w_rem_nxt;
          r_quo <= w_quo_nxt;
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) begin
            r_result <= w_div_res;
            r_state  <= S_DONE;
          end
        end
        default: begin
          if (I_allowout) r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign O_alu_output_valid = ((r_state == S_IDLE) && !I_start) || (r_state == S_DONE);
  assign O_busy             = (r_state != S_IDLE);
  assign O_result           = r_result;

endmodule
